// File: rtl/sha256_arb.sv
// Round-robin arbiter sharing one sha256_1024in hasher among NUM_REQ requesters; SHA_ARB_PRIO_EN gives requester 0 strict priority.
// Latency: grant -> h_in_valid next cycle; hasher digest -> rsp_valid next cycle; one job in flight.
// Backpressure: no new grant until the owner accepts its digest; h_in and rsp_data hold while waiting.
module sha256_arb #(
  parameter int NUM_REQ = 4,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*1024-1:0] req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [255:0]            rsp_data,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [1023:0]           h_in,
  output logic                    h_in_valid,
  input  logic                    h_in_ready,
  input  logic [255:0]            h_out,
  input  logic                    h_out_valid,
  output logic                    h_out_ready,
  output logic                    h_rst,
  output logic                    busy_o,
  output logic [IDW-1:0]          owner_o
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_RETURN} state_t;

  state_t         state;
  logic [IDW-1:0] rr;
  logic [IDW-1:0] owner;
  logic [1023:0]  msg;
  logic [255:0]   dig;

  logic [IDW-1:0] grant;
  logic           grant_vld;
  logic [IDW:0]   cand_sum;
  logic [IDW-1:0] cand;

  // Search starts at rr and wraps; with priority enabled requester 0 is
  // pulled out of the rotation and checked first.
  always_comb begin
    grant     = '0;
    grant_vld = 1'b0;
    cand_sum  = '0;
    cand      = '0;
`ifdef SHA_ARB_PRIO_EN
    if (req_valid[0]) begin
      grant     = '0;
      grant_vld = 1'b1;
    end
`endif
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr} + (IDW+1)'(k);
      if (cand_sum >= (IDW+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (IDW+1)'(NUM_REQ);
      end
      cand = cand_sum[IDW-1:0];
`ifdef SHA_ARB_PRIO_EN
      if (!grant_vld && (cand != '0) && req_valid[cand]) begin
`else
      if (!grant_vld && req_valid[cand]) begin
`endif
        grant     = cand;
        grant_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
      rr    <= '0;
      owner <= '0;
      msg   <= '0;
      dig   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_vld) begin
            msg   <= req_data[int'(grant)*1024 +: 1024];
            owner <= grant;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (h_in_ready) begin
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (h_out_valid) begin
            dig   <= h_out;
            state <= S_RETURN;
          end
        end
        S_RETURN: begin
          if (rsp_ready[owner]) begin
            rr    <= (owner == IDW'(NUM_REQ-1)) ? '0 : owner + IDW'(1);
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Handshake outputs are masked by rst_i so the reset cycle itself is quiet.
  assign req_ready   = (!rst_i && state == S_IDLE && grant_vld) ? (NUM_REQ'(1) << grant) : '0;
  assign rsp_valid   = (!rst_i && state == S_RETURN) ? (NUM_REQ'(1) << owner) : '0;
  assign h_in_valid  = !rst_i && (state == S_ISSUE);
  assign h_out_ready = !rst_i && (state == S_BUSY);
  assign busy_o      = !rst_i && (state != S_IDLE);
  assign h_in        = msg;
  assign rsp_data    = dig;
  assign owner_o     = owner;
  assign h_rst       = rst_i;

endmodule

// File: tb/tb_sha256_arb.sv
// Bench for sha256_arb: table of grant vectors, directed corner sequences, then random jobs
// checked against a round-robin reference model; a behavioural hasher with settable latency.
module tb_sha256_arb;
  localparam int NR  = 4;
  localparam int IDW = 2;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic [NR-1:0]     req_valid = '0;
  logic [NR*1024-1:0] req_data = '0;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic [255:0]      rsp_data;
  logic [NR-1:0]     rsp_ready = '0;
  logic [1023:0]     h_in;
  logic              h_in_valid;
  logic              h_in_ready;
  logic [255:0]      h_out;
  logic              h_out_valid;
  logic              h_out_ready;
  logic              h_rst;
  logic              busy_o;
  logic [IDW-1:0]    owner_o;

  sha256_arb #(.NUM_REQ(NR)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .h_in(h_in), .h_in_valid(h_in_valid), .h_in_ready(h_in_ready),
    .h_out(h_out), .h_out_valid(h_out_valid), .h_out_ready(h_out_ready),
    .h_rst(h_rst), .busy_o(busy_o), .owner_o(owner_o)
  );

  initial forever #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int rr_m = 0;

  // Stand-in digest: quarter-rotated XOR fold, so misrouted or swapped data shows up.
  function automatic logic [255:0] fold(input logic [1023:0] m);
    logic [255:0] t;
    t = m[1023:768];
    return m[255:0] ^ m[511:256] ^ m[767:512] ^ {t[127:0], t[255:128]};
  endfunction

  function automatic logic [NR-1:0] onehot(input int g);
    logic [NR-1:0] r;
    r = '0;
    if (g >= 0 && g < NR) r[g] = 1'b1;
    return r;
  endfunction

  function automatic int oh2idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v[i]) return i;
    return -1;
  endfunction

  function automatic int model_grant(input logic [NR-1:0] v, input int rr);
`ifdef SHA_ARB_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int k = 0; k < NR; k++) begin
      int c;
      c = (rr + k) % NR;
`ifdef SHA_ARB_PRIO_EN
      if (c == 0) continue;
`endif
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Behavioural hasher: accepts when idle, answers hlat+1 cycles later, holds until taken.
  int            hlat = 3;
  logic          hin_gate = 1'b1;
  logic          hv_inject = 1'b0;
  logic          hs_busy, hs_done;
  int            hs_cnt;
  logic [1023:0] hs_msg;

  assign h_in_ready  = !hs_busy && hin_gate;
  assign h_out_valid = hs_done || hv_inject;
  assign h_out       = fold(hs_msg);

  always @(posedge clk_i) begin
    if (h_rst) begin
      hs_busy <= 1'b0; hs_done <= 1'b0; hs_cnt <= 0; hs_msg <= '0;
    end else if (!hs_busy) begin
      if (h_in_valid && h_in_ready) begin
        hs_busy <= 1'b1; hs_cnt <= hlat; hs_msg <= h_in;
      end
    end else if (!hs_done) begin
      if (hs_cnt == 0) hs_done <= 1'b1;
      else hs_cnt <= hs_cnt - 1;
    end else if (h_out_ready) begin
      hs_busy <= 1'b0; hs_done <= 1'b0;
    end
  end

  logic [1023:0] force_msg = {32'h61626380, 928'h0, 64'h18};
  bit            use_force = 1'b0;

  // One full job; hold cycles keep the owner's rsp_ready low while noise drives the others.
  task automatic run_job(input logic [NR-1:0] vld, input int g, input bit rnd,
                         input int hold, input logic [NR-1:0] noise);
    logic [1023:0] d [NR];
    logic [NR-1:0] oh;
    bit hs_prev, done;
    int n;
    oh = onehot(g);
    for (int i = 0; i < NR; i++)
      for (int w = 0; w < 32; w++) d[i][w*32 +: 32] = $urandom;
    if (use_force) d[g] = force_msg;
    @(negedge clk_i);
    for (int i = 0; i < NR; i++) req_data[i*1024 +: 1024] = d[i];
    req_valid = vld;
    #1;
    chk("req_ready", req_ready, oh);
    @(negedge clk_i);
    req_valid = '0;
    #1;
    chk("h_in_valid_t1", h_in_valid, 1'b1);
    chk("owner", owner_o, g);
    for (int q = 0; q < 4; q++) chk("h_in", h_in[q*256 +: 256], d[g][q*256 +: 256]);
    n = 0; done = 0; hs_prev = 0;
    while (!done && n < 300) begin
      if (hs_prev) chk("rsp_latency", rsp_valid, oh);
      if (h_in_valid) chk("h_in_hold", fold(h_in), fold(d[g]));
      if (rsp_valid != '0) done = 1;
      else begin
        hs_prev = h_out_valid && h_out_ready;
        @(negedge clk_i);
        if (rnd) hin_gate = 1'($urandom_range(0, 1));
        #1;
        n++;
      end
    end
    hin_gate = 1'b1;
    if (!done) chk("rsp_timeout", 0, 1);
    chk("rsp_valid", rsp_valid, oh);
    chk("rsp_data", rsp_data, fold(d[g]));
    chk("busy_return", busy_o, 1'b1);
    for (int h = 0; h < hold; h++) begin
      rsp_ready = noise & ~oh;
      req_valid = '1;
      @(negedge clk_i);
      #1;
      chk("hold_rsp_valid", rsp_valid, oh);
      chk("hold_rsp_data", rsp_data, fold(d[g]));
      chk("hold_req_ready", req_ready, '0);
      chk("hold_h_in_valid", h_in_valid, 1'b0);
    end
    rsp_ready = oh;
    req_valid = '0;
    @(negedge clk_i);
    rsp_ready = '0;
    #1;
    chk("rsp_release", rsp_valid, '0);
    chk("idle_busy", busy_o, 1'b0);
    rr_m = (g + 1) % NR;
  endtask

  typedef struct {
    logic [NR-1:0] vld;
    int            g;
  } vec_t;

  vec_t tbl [11];
  int   ord [5];
  int   ng, cyc, last_rsp, n, ev;
  logic [NR-1:0] rv;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{4'b0100, 2};
`ifdef SHA_ARB_PRIO_EN
    tbl[1]  = '{4'b1001, 0};
`else
    tbl[1]  = '{4'b1001, 3};
`endif
    tbl[2]  = '{4'b1111, 0};
    tbl[3]  = '{4'b0001, 0};
    tbl[4]  = '{4'b1110, 1};
    tbl[5]  = '{4'b0011, 0};
    tbl[6]  = '{4'b1010, 1};
    tbl[7]  = '{4'b1000, 3};
    tbl[8]  = '{4'b0110, 1};
    tbl[9]  = '{4'b1100, 2};
    tbl[10] = '{4'b0011, 0};

    // Reset with every requester asking: all handshakes must stay low.
    @(negedge clk_i);
    rst_i = 1'b1; req_valid = '1;
    @(negedge clk_i);
    #1;
    chk("rst_req_ready", req_ready, '0);
    chk("rst_rsp_valid", rsp_valid, '0);
    chk("rst_h_in_valid", h_in_valid, 1'b0);
    chk("rst_h_out_ready", h_out_ready, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_owner", owner_o, 0);
    chk("rst_rsp_data", rsp_data, '0);
    chk("rst_h_in_lo", h_in[255:0], '0);
    chk("rst_h_in_hi", h_in[1023:768], '0);
    @(negedge clk_i);
    rst_i = 1'b0; req_valid = '0; rr_m = 0;
    #1;
    chk("idle_no_req", req_ready, '0);

    for (int i = 0; i < 11; i++) begin
      use_force = (i == 0);
      hlat = 3;
      run_job(tbl[i].vld, tbl[i].g, 1'b0, 0, '0);
    end
    use_force = 1'b0;

    run_job(4'b1000, 3, 1'b0, 5, 4'b0000);
    run_job(4'b0010, 1, 1'b0, 1, 4'b1111);

    // Reset while the hasher is working; a later stray digest must be dropped.
    hlat = 10;
    @(negedge clk_i);
    req_valid = 4'b0100;
    @(negedge clk_i);
    req_valid = '0;
    #1;
    n = 0;
    while (!h_out_ready && n < 50) begin
      @(negedge clk_i); #1; n++;
    end
    chk("reached_busy", h_out_ready, 1'b1);
    rst_i = 1'b1; req_valid = '1;
    #1;
    chk("midjob_rst_busy", busy_o, 1'b0);
    chk("midjob_rst_req_ready", req_ready, '0);
    chk("midjob_rst_h_out_ready", h_out_ready, 1'b0);
    @(negedge clk_i);
    rst_i = 1'b0; req_valid = '0;
    #1;
    chk("post_rst_busy", busy_o, 1'b0);
    chk("post_rst_rsp_valid", rsp_valid, '0);
    hv_inject = 1'b1;
    @(negedge clk_i);
    hv_inject = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("stray_rsp_valid", rsp_valid, '0);
      chk("stray_busy", busy_o, 1'b0);
      @(negedge clk_i);
    end
    rr_m = 0;
    hlat = 2;
    run_job(4'b1111, 0, 1'b0, 0, '0);

    // Everyone continuously valid, responses always accepted.
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0; rr_m = 0;
    hlat = 10; hin_gate = 1'b1;
    req_valid = '1; rsp_ready = '1;
    for (int k = 0; k < 5; k++) ord[k] = -1;
    ng = 0; cyc = 0; last_rsp = -100;
    while (ng < 5 && cyc < 400) begin
      #1;
      if (rsp_valid != '0) last_rsp = cyc;
      if (req_ready != '0) begin
        ord[ng] = oh2idx(req_ready);
        if (ng > 0) chk("regrant_gap", cyc - last_rsp, 1);
        ng++;
      end
      @(negedge clk_i);
      cyc++;
    end
    if (ng < 5) chk("fair_timeout", ng, 5);
    for (int k = 0; k < 5; k++) begin
`ifdef SHA_ARB_PRIO_EN
      ev = 0;
`else
      ev = k % NR;
`endif
      chk("rr_order", ord[k], ev);
    end
    req_valid = '0;
    n = 0;
    #1;
    while (busy_o && n < 100) begin
      @(negedge clk_i); #1; n++;
    end
    chk("drain_busy", busy_o, 1'b0);
    rsp_ready = '0;
    rr_m = (ord[4] + 1) % NR;

    for (int j = 0; j < 40; j++) begin
      rv = NR'($urandom_range(0, 15));
      if (rv == '0) begin
        @(negedge clk_i);
        req_valid = '0;
        #1;
        chk("rand_idle_ready", req_ready, '0);
        chk("rand_idle_busy", busy_o, 1'b0);
      end else begin
        hlat = $urandom_range(0, 6);
        run_job(rv, model_grant(rv, rr_m), 1'b1, $urandom_range(0, 3), NR'($urandom));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
